// File: rtl/uart_frame_parser_pkg.sv
// Shared constants and FSM encoding for the UART frame parser.
// Error codes travel on err_code alongside the frame_err pulse.
package uart_frame_parser_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hAA;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHK  = 2'd1;
    localparam logic [1:0] ERR_LEN  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4
    } state_t;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Bundle between the frame parser, its receive FIFO, the payload sink and status consumers.
// master = the parser, slave = everything around it.
interface uart_frame_parser_if;

    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_rd;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic [7:0] frame_addr;
    logic [7:0] frame_len;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;

    modport master (
        input  rx_empty, rx_data, pl_ready,
        output rx_rd, pl_valid, pl_data,
        output frame_addr, frame_len, frame_done, frame_err, err_code
    );

    modport slave (
        output rx_empty, rx_data, pl_ready,
        input  rx_rd, pl_valid, pl_data,
        input  frame_addr, frame_len, frame_done, frame_err, err_code
    );

endinterface

// File: rtl/uart_frame_parser.sv
// Pops bytes from a show-ahead receive FIFO and parses SOF/ADDR/LEN/payload/CHK frames,
// streaming payload straight through and flagging completion or abort with a one-cycle pulse.
module uart_frame_parser
    import uart_frame_parser_pkg::*;
#(
    parameter logic [7:0] SOF     = SOF_DEFAULT,
    parameter int         MAX_LEN = 16,
    parameter int         TIMEOUT = 1000,
    parameter int         TW      = 10
) (
    input logic                 clk,
    input logic                 reset,
    uart_frame_parser_if.master bus
);

    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    state_t        state, state_nxt;
    logic [7:0]    chk, chk_nxt;
    logic [7:0]    cnt, cnt_nxt;
    logic [7:0]    addr_q, addr_nxt;
    logic [7:0]    len_q, len_nxt;
    logic          done_q, done_nxt;
    logic          err_q, err_nxt;
    logic [1:0]    code_q, code_nxt;
    logic [TW-1:0] tmo;
    logic          pop, tmo_hit;
    logic [7:0]    b;

    // Payload is a zero-latency pass-through: a stalled sink simply holds the FIFO head.
    assign pop     = !bus.rx_empty && (state != ST_PAYLOAD || bus.pl_ready);
    assign b       = bus.rx_data;
    assign tmo_hit = (state != ST_IDLE) && !pop && (tmo == TMO_LAST);

    assign bus.rx_rd      = pop;
    assign bus.pl_valid   = (state == ST_PAYLOAD) && !bus.rx_empty;
    assign bus.pl_data    = bus.rx_data;
    assign bus.frame_addr = addr_q;
    assign bus.frame_len  = len_q;
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.err_code   = code_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            chk    <= 8'h00;
            cnt    <= 8'h00;
            addr_q <= 8'h00;
            len_q  <= 8'h00;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            code_q <= ERR_NONE;
        end else begin
            state  <= state_nxt;
            chk    <= chk_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            len_q  <= len_nxt;
            done_q <= done_nxt;
            err_q  <= err_nxt;
            code_q <= code_nxt;
        end
    end

    // Counts idle/stalled cycles inside a frame; any pop restarts the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo <= '0;
        else if (pop || state == ST_IDLE)
            tmo <= '0;
        else
            tmo <= tmo + TW'(1);
    end

    always_comb begin
        state_nxt = state;
        chk_nxt   = chk;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        len_nxt   = len_q;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = code_q;
        if (pop) begin
            unique case (state)
                ST_IDLE: begin
                    if (b == SOF) state_nxt = ST_ADDR;
                end
                ST_ADDR: begin
                    addr_nxt  = b;
                    chk_nxt   = b;
                    state_nxt = ST_LEN;
                end
                ST_LEN: begin
                    if (b > MAX_LEN_B) begin
                        err_nxt   = 1'b1;
                        code_nxt  = ERR_LEN;
                        state_nxt = ST_IDLE;
                    end else begin
                        len_nxt   = b;
                        chk_nxt   = chk ^ b;
                        cnt_nxt   = b;
                        state_nxt = (b == 8'h00) ? ST_CHK : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    chk_nxt = chk ^ b;
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) state_nxt = ST_CHK;
                end
                ST_CHK: begin
                    if (b == chk) begin
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt  = 1'b1;
                        code_nxt = ERR_CHK;
                    end
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (tmo_hit) begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_TMO;
            state_nxt = ST_IDLE;
        end
    end

endmodule
